// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the HI/LO scheduler: op encodings, FSM states, data width.
package muldiv_sched_pkg;

  localparam int W_DATA = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } md_state_e;

  // Ops that occupy the iterative core (as opposed to plain HI/LO moves).
  function automatic logic is_unit_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sched_watchdog.sv
// Busy-cycle watchdog: counts consecutive waiting cycles and raises a sticky error.
module md_watchdog #(
  parameter int TIMEOUT = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_cycle,
  output logic expire,
  output logic wdog_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Fires in the TIMEOUT-th consecutive waiting cycle.
  assign expire = busy_cycle && (cnt == CW'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (expire) wdog_err <= 1'b1;
      cnt <= (busy_cycle && !expire) ? cnt + CW'(1) : '0;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO owner and launch scheduler for the iterative multiply/divide core.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int TIMEOUT = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [W_DATA-1:0] req_a,
  input  logic [W_DATA-1:0] req_b,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              req_stall,
  output logic [W_DATA-1:0] rd_data,
  output logic              unit_start,
  output logic              unit_div,
  output logic              unit_sign,
  output logic [W_DATA-1:0] unit_a,
  output logic [W_DATA-1:0] unit_b,
  input  logic              unit_done,
  input  logic [W_DATA-1:0] unit_hi,
  input  logic [W_DATA-1:0] unit_lo,
  output logic [W_DATA-1:0] hi,
  output logic [W_DATA-1:0] lo,
  output logic              busy,
  output logic              wdog_err
);

  md_state_e state, state_nx;
  md_op_e    op;
  logic      fire, accept, commit, expire;

  assign op         = md_op_e'(req_op);
  assign req_stall  = req_valid && (state != ST_IDLE);
  assign fire       = req_valid && !pipe_stall && !flush && !req_stall;
  assign unit_start = (state == ST_LAUNCH);
  assign busy       = (state != ST_IDLE);

  md_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .busy_cycle ((state == ST_BUSY) && !unit_done),
    .expire     (expire),
    .wdog_err   (wdog_err)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fire && is_unit_op(op)) begin
          accept   = 1'b1;
          state_nx = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nx = ST_BUSY;
      ST_BUSY: begin
        // A completion in the expiry cycle still wins: the result is real.
        if (unit_done) begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end else if (expire) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Reads are served only from IDLE; while busy the requester is stalled anyway.
  always_comb begin
    rd_data = '0;
    if (state == ST_IDLE) begin
      if (op == MD_MFHI) rd_data = hi;
      else if (op == MD_MFLO) rd_data = lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hi        <= '0;
      lo        <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      unit_div  <= 1'b0;
      unit_sign <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        unit_a    <= req_a;
        unit_b    <= req_b;
        unit_div  <= (op == MD_DIV) || (op == MD_DIVU);
        unit_sign <= (op == MD_MULT) || (op == MD_DIV);
      end
      // Commit and moves are exclusive: moves only fire from IDLE.
      if (commit) begin
        hi <= unit_hi;
        lo <= unit_lo;
      end else if (fire) begin
        if (op == MD_MTHI) hi <= req_a;
        if (op == MD_MTLO) lo <= req_a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench: behavioural scheduler model plus a mul/div core model.
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  localparam int TIMEOUT = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        pipe_stall = 1'b0, flush = 1'b0;
  logic        req_stall, unit_start, unit_div, unit_sign, busy, wdog_err;
  logic [31:0] rd_data, unit_a, unit_b, hi, lo;
  logic        unit_done = 1'b0;
  logic [31:0] unit_hi = '0, unit_lo = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .pipe_stall(pipe_stall), .flush(flush), .req_stall(req_stall), .rd_data(rd_data),
    .unit_start(unit_start), .unit_div(unit_div), .unit_sign(unit_sign), .unit_a(unit_a),
    .unit_b(unit_b), .unit_done(unit_done), .unit_hi(unit_hi), .unit_lo(unit_lo),
    .hi(hi), .lo(lo), .busy(busy), .wdog_err(wdog_err)
  );

  // ---------------- core model: plain arithmetic, configurable latency ----------------
  int          core_lat = 0;   // 0 selects a random latency per launch
  bit          core_en = 1'b1;
  int          stray_cnt = 0, stray_seen = 0;
  int          cd = 0;
  logic [31:0] res_hi = '0, res_lo = '0;

  function automatic void core_calc(input logic div, input logic sgn, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] h,
                                    output logic [31:0] l);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    if (!div) begin
      if (sgn) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        {h, l} = sp;
      end else begin
        up = {32'b0, a} * {32'b0, b};
        {h, l} = up;
      end
    end else if (b == 0) begin
      l = '1;
      h = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      l = a;
      h = '0;
    end else if (sgn) begin
      l = $signed(a) / $signed(b);
      h = $signed(a) % $signed(b);
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    unit_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        unit_done = 1'b1;
        unit_hi   = res_hi;
        unit_lo   = res_lo;
      end
    end
    if (stray_cnt != stray_seen) begin
      stray_seen = stray_cnt;
      unit_done  = 1'b1;
      unit_hi    = 32'hDEAD_BEEF;
      unit_lo    = 32'hBAD0_F00D;
    end
    if (unit_start && core_en) begin
      core_calc(unit_div, unit_sign, unit_a, unit_b, res_hi, res_lo);
      cd = (core_lat > 0) ? core_lat : int'($urandom_range(1, 34));
    end
  end

  // ---------------- scheduler model: an in-flight flag plus its age ----------------
  bit          model_valid = 1'b0;
  bit          m_inflight = 1'b0;
  int          m_age = 0;       // 0 = launch cycle, k>=1 = k-th waiting cycle
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic        m_div = 1'b0, m_sgn = 1'b0, m_wdog = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1'b1;
      m_inflight  = 1'b0;
      m_age       = 0;
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
      m_div = 1'b0; m_sgn = 1'b0; m_wdog = 1'b0;
    end else if (m_inflight) begin
      if (m_age == 0) m_age = 1;
      else if (unit_done) begin
        m_hi = unit_hi;
        m_lo = unit_lo;
        m_inflight = 1'b0;
      end else if (m_age == TIMEOUT) begin
        m_wdog = 1'b1;
        m_inflight = 1'b0;
      end else m_age++;
    end else if (req_valid && !pipe_stall && !flush) begin
      if (req_op <= 3'd3) begin
        m_inflight = 1'b1;
        m_age = 0;
        m_a = req_a;
        m_b = req_b;
        m_div = (req_op == MD_DIV) || (req_op == MD_DIVU);
        m_sgn = (req_op == MD_MULT) || (req_op == MD_DIV);
      end else if (req_op == MD_MTHI) m_hi = req_a;
      else if (req_op == MD_MTLO) m_lo = req_a;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic [31:0] exp_rd;
    if (!model_valid) return;
    check("busy", 32'(busy), 32'(m_inflight));
    check("unit_start", 32'(unit_start), 32'(m_inflight && m_age == 0));
    check("req_stall", 32'(req_stall), 32'(req_valid && m_inflight));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("wdog_err", 32'(wdog_err), 32'(m_wdog));
    if (!m_inflight) begin
      exp_rd = (req_op == MD_MFHI) ? m_hi : (req_op == MD_MFLO) ? m_lo : '0;
      check("rd_data", rd_data, exp_rd);
    end
    if (m_inflight && m_age == 0) begin
      check("unit_a", unit_a, m_a);
      check("unit_b", unit_b, m_b);
      check("unit_div", 32'(unit_div), 32'(m_div));
      check("unit_sign", 32'(unit_sign), 32'(m_sgn));
    end
  endtask

  // One clock: compare on the falling edge, return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_op = MD_MULT; req_a = '0; req_b = '0;
    pipe_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
  endtask

  task automatic wait_idle(input int max, inout int starts, inout int n);
    while (busy && n < max) begin
      cycle();
      n++;
      if (unit_start) starts++;
    end
    if (busy) check("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int starts, n, stalls;
    idle_req();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Signed MULT -2 * 3 with a 10-cycle core.
    core_lat = 10;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    cycle();
    check("mult_start_after_fire", 32'(unit_start), 32'd1);
    idle_req();
    starts = 1; n = 1;
    wait_idle(100, starts, n);
    check("mult_start_count", starts, 32'd1);
    check("mult_idle_cycle", n, 32'd12);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // DIVU 100/7 followed immediately by a dependent MFLO.
    core_lat = 5;
    issue(MD_DIVU, 32'd100, 32'd7);
    cycle();
    issue(MD_MFLO, 32'd0, 32'd0);
    #1;
    stalls = 0;
    while (req_stall && stalls < 100) begin
      stalls++;
      cycle();
      #1;
    end
    check("divu_stall_cycles", stalls, 32'd6);
    check("divu_busy_at_release", 32'(busy), 32'd0);
    check("divu_mflo", rd_data, 32'd14);
    cycle();
    issue(MD_MFHI, 32'd0, 32'd0);
    #1;
    check("divu_mfhi", rd_data, 32'd2);
    cycle();

    // MTHI then MFHI without a stall.
    issue(MD_MTHI, 32'h1234, 32'd0);
    cycle();
    issue(MD_MFHI, 32'd0, 32'd0);
    #1;
    check("mthi_mfhi", rd_data, 32'h1234);
    check("mfhi_no_stall", 32'(req_stall), 32'd0);
    cycle();

    // MTLO issued while busy waits for the commit, then overwrites LO.
    core_lat = 8;
    issue(MD_MULT, 32'd5, 32'd6);
    cycle();
    issue(MD_MTLO, 32'h55, 32'd0);
    n = 0;
    while (req_stall && n < 100) begin cycle(); n++; end
    check("mtlo_after_commit_lo", lo, 32'd30);
    cycle();
    idle_req();
    check("mtlo_written", lo, 32'h55);

    // Flushed MULT never launches; an accepted one survives a younger flush.
    issue(MD_MULT, 32'd9, 32'd9);
    flush = 1'b1;
    cycle();
    check("flush_no_start", 32'(unit_start), 32'd0);
    check("flush_idle", 32'(busy), 32'd0);
    flush = 1'b0;
    core_lat = 6;
    issue(MD_MULT, 32'd7, 32'd8);
    cycle();
    issue(MD_MFHI, 32'd0, 32'd0);
    flush = 1'b1;
    cycle();
    idle_req();
    starts = 0; n = 0;
    wait_idle(100, starts, n);
    check("flush_commit_lo", lo, 32'd56);
    check("flush_commit_hi", hi, 32'd0);

    // Held request under pipe_stall launches exactly once.
    issue(MD_MULTU, 32'd3, 32'd4);
    pipe_stall = 1'b1;
    starts = 0;
    repeat (3) begin cycle(); if (unit_start) starts++; end
    pipe_stall = 1'b0;
    cycle();
    if (unit_start) starts++;
    idle_req();
    n = 0;
    wait_idle(100, starts, n);
    check("pipe_stall_one_start", starts, 32'd1);
    check("pipe_stall_lo", lo, 32'd12);

    // Reset mid-operation; the late completion and a stray pulse are ignored.
    core_lat = 20;
    issue(MD_MULTU, 32'h10, 32'h10);
    cycle();
    idle_req();
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (20) cycle();
    stray_cnt++;
    repeat (3) cycle();
    check("stray_hi", hi, 32'd0);
    check("stray_lo", lo, 32'd0);

    // Randomised traffic against the model.
    core_lat = 0;
    repeat (700) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_op     = 3'($urandom_range(0, 7));
      req_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      req_b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      pipe_stall = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_req();
    repeat (40) cycle();

    // Core never answers: watchdog trips, HI/LO kept, unit stays usable.
    issue(MD_MTHI, 32'hAAAA, 32'd0);
    cycle();
    issue(MD_MTLO, 32'hBBBB, 32'd0);
    cycle();
    core_en = 1'b0;
    issue(MD_MULT, 32'd2, 32'd2);
    cycle();
    idle_req();
    starts = 1; n = 1;
    wait_idle(300, starts, n);
    check("wdog_idle_cycle", n, 32'(TIMEOUT + 2));
    check("wdog_err_set", 32'(wdog_err), 32'd1);
    check("wdog_hi_kept", hi, 32'hAAAA);
    check("wdog_lo_kept", lo, 32'hBBBB);
    core_en = 1'b1;
    core_lat = 4;
    issue(MD_MTHI, 32'hC0DE, 32'd0);
    cycle();
    check("wdog_mthi_accepted", hi, 32'hC0DE);
    issue(MD_MULT, 32'd4, 32'd5);
    cycle();
    idle_req();
    starts = 1; n = 1;
    wait_idle(100, starts, n);
    check("wdog_mult_after", lo, 32'd20);
    check("wdog_sticky", 32'(wdog_err), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("wdog_cleared_by_rst", 32'(wdog_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Scheduler and owner of the architectural HI/LO pair for the iterative multiply/divide unit.
- Accepts HI/LO-class instructions from the EX stage and launches MULT/MULTU/DIV/DIVU on the iterative unit with a one-cycle start pulse.
- Lets the pipeline run ahead while the unit computes. Stalls only on a true HI/LO dependency, then commits the unit result into HI/LO.
- Sits between EX-stage decode and a pure-compute mul/div core with a start/done interface.

Parameters:
- TIMEOUT, 80, maximum BUSY cycles before the watchdog error flag sets (must be > worst-case divide latency, ~34).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EX stage holds a HI/LO-class instruction
- req_op  in  3  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- pipe_stall  in  1  EX held by another stall source; no request may fire
- flush  in  1  EX instruction is being killed this cycle
- req_stall  out  1  request cannot complete this cycle; the pipeline must hold EX
- rd_data  out  32  MFHI/MFLO result, valid when req_stall=0
- unit_start  out  1  one-cycle launch pulse to the mul/div core
- unit_div  out  1  1=divide, 0=multiply
- unit_sign  out  1  signed operation
- unit_a  out  32  registered operand a
- unit_b  out  32  registered operand b
- unit_done  in  1  one-cycle completion pulse from the core
- unit_hi  in  32  core result high / remainder
- unit_lo  in  32  core result low / quotient
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- wdog_err  out  1  sticky watchdog error

Behaviour:
- rst: state=IDLE, hi=lo=0, unit_start=0, unit_a=unit_b=0, busy=0, wdog_err=0, counter=0.
- fire = req_valid & ~pipe_stall & ~flush & ~req_stall.
- States:
  - IDLE: no operation in flight.
  - LAUNCH: unit_start=1 for exactly this cycle.
  - BUSY: waiting on unit_done.
- req_stall = req_valid & (state≠IDLE). Any HI/LO op, including a new MULT/DIV, waits while an operation is in flight. Non-HI/LO instructions never stall.
- IDLE + fire with MULT/DIV/U:
  - Latch operands and unit_div/unit_sign; go to LAUNCH.
  - The instruction retires without a stall.
- LAUNCH -> BUSY unconditionally; busy=1 in LAUNCH and BUSY.
- BUSY + unit_done:
  - hi<=unit_hi, lo<=unit_lo; go to IDLE.
  - A dependent MF in that same cycle still sees req_stall=1 and reads the updated register next cycle (no bypass).
- unit_done outside BUSY is ignored. It must not modify HI/LO.
- MTHI/MTLO in IDLE with fire: write req_a to hi/lo at the clock edge.
- MFHI/MFLO in IDLE: rd_data = hi/lo combinationally.
- rd_data = 0 when the op is not MF.
- flush suppresses fire only. An operation already accepted (LAUNCH/BUSY) completes and commits, because it is older than the flushed instruction.
- pipe_stall with req_valid held across cycles: accepted at most once, because fire is gated.
- Watchdog:
  - Counter increments each BUSY cycle and clears on leaving BUSY.
  - When it reaches TIMEOUT, wdog_err<=1 and the FSM forces IDLE without a commit.
  - wdog_err clears only on rst.
- rst mid-operation returns the FSM to IDLE. A later stray unit_done is ignored.

Decomposition:
- Shared package (defines.vh): MD_* op encodings, width `W_DATA, state localparams.
- One sub-module is natural: md_watchdog (counter + sticky flag, parameter TIMEOUT).
- The FSM, the HI/LO registers and the stall logic stay in muldiv_sched.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 (signed):
  - unit_start pulses once, one cycle after fire.
  - The core model returns done after 10 cycles; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - busy drops the same edge.
- DIVU 100/7 followed immediately by MFLO:
  - req_stall=1 until the done cycle inclusive.
  - Next cycle rd_data=14; a subsequent MFHI reads 2.
- MTHI 0x1234 in IDLE, then MFHI -> rd_data=0x1234 with no stall. MTLO issued while BUSY -> stalls and writes only after commit.
- MULT with flush=1 -> no unit_start, state stays IDLE. MULT accepted, then flush on the next instruction -> the result still commits.
- MULT with pipe_stall=1 for 3 cycles then 0 -> exactly one unit_start.
- Core never returns done -> wdog_err=1 after TIMEOUT BUSY cycles, state=IDLE, hi/lo unchanged, new requests accepted.
